// File: rtl/ic_ne_bvudiv_checker.sv
// ---------------------------------------------------------------------------
// ic_ne_bvudiv_checker
//   Sequential witness checker for the bvudiv disequality (x bvudiv s) != t.
//   A candidate (x, s, t) is latched on an in_valid/in_ready handshake. The
//   quotient and remainder are then produced by restoring division, one
//   quotient bit per cycle, using SMT-LIB semantics (division by zero yields
//   all-ones quotient and remainder x). The result is then offered on an
//   out_valid/out_ready handshake.
//
//   Optional feature macro: IC_CHECK_EN
//     defined   : ic is registered on entry to DONE as (s!=0) | (t!=all-ones),
//                 and a simulation checker flags ne_holds & ~ic while in DONE.
//     undefined : ic is tied to 0 and no invertibility logic is built.
//
// Parameters
//   W          operand width, legal range 2..32
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_valid   request valid
//   in_ready   idle, able to accept a request (registered)
//   x, s, t    dividend, divisor, value the quotient must differ from
//   out_valid  result valid (registered)
//   out_ready  consumer accepts the result
//   quot, rem  x bvudiv s, x bvurem s
//   ne_holds   quot != t
//   div_zero   divisor was zero
//   ic         invertibility condition (0 when IC_CHECK_EN is undefined)
// ---------------------------------------------------------------------------
module ic_ne_bvudiv_checker #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] s,
  input  logic [W-1:0] t,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic [W-1:0] rem,
  output logic         ne_holds,
  output logic         div_zero,
  output logic         ic
);

  localparam int             CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(W - 1);
  localparam logic [CW-1:0]  CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]  CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   ALL_ONES = {W{1'b1}};
  localparam logic [W-1:0]   ALL_ZERO = {W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // One restoring-division step: returns {quotient bit, next partial remainder}.
  // The trial value is compared at W+1 bits so the shifted-out MSB is kept.
  // When the subtraction is taken the result is below s, so W bits suffice.
  function automatic logic [W:0] div_step(input logic [W-1:0] rem_in,
                                          input logic         bit_in,
                                          input logic [W-1:0] div_in);
    logic [W:0] trial;
    trial = {rem_in, bit_in};
    if (trial >= {1'b0, div_in}) begin
      div_step = {1'b1, trial[W-1:0] - div_in};
    end else begin
      div_step = {1'b0, trial[W-1:0]};
    end
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  t_q, t_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          ne_holds_q, ne_holds_d;
  logic          div_zero_q, div_zero_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [W:0]    step_s;
  logic [W-1:0]  quot_next_s;
`ifdef IC_CHECK_EN
  logic          ic_q, ic_d;
`endif

  // Next-state, datapath and handshake logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    x_d         = x_q;
    s_d         = s_q;
    t_d         = t_q;
    quot_d      = quot_q;
    rem_d       = rem_q;
    ne_holds_d  = ne_holds_q;
    div_zero_d  = div_zero_q;
`ifdef IC_CHECK_EN
    ic_d        = ic_q;
`endif
    step_s      = div_step(rem_q, x_q[count_q], s_q);
    // Quotient is shifted in MSB first, which places each bit at index count.
    quot_next_s = {quot_q[W-2:0], step_s[W]};

    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d = x;
          s_d = s;
          t_d = t;
          if (s != ALL_ZERO) begin
            state_d    = ST_DIV;
            count_d    = CNT_INIT;
            quot_d     = ALL_ZERO;
            rem_d      = ALL_ZERO;
            div_zero_d = 1'b0;
          end else begin
            // Division by zero resolves immediately with SMT-LIB results.
            state_d    = ST_DONE;
            quot_d     = ALL_ONES;
            rem_d      = x;
            div_zero_d = 1'b1;
            ne_holds_d = (ALL_ONES != t);
`ifdef IC_CHECK_EN
            ic_d       = (t != ALL_ONES);
`endif
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DIV: begin
        quot_d = quot_next_s;
        rem_d  = step_s[W-1:0];
        if (count_q == CNT_ZERO) begin
          state_d    = ST_DONE;
          ne_holds_d = (quot_next_s != t_q);
`ifdef IC_CHECK_EN
          ic_d       = (s_q != ALL_ZERO) | (t_q != ALL_ONES);
`endif
        end else begin
          count_d = count_q - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // out_valid rises one cycle after DONE is entered, which gives the
    // W+1 / 1 cycle acceptance-to-valid latency, and drops on the handshake.
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_q == ST_DONE) && (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= CNT_ZERO;
      x_q         <= ALL_ZERO;
      s_q         <= ALL_ZERO;
      t_q         <= ALL_ZERO;
      quot_q      <= ALL_ZERO;
      rem_q       <= ALL_ZERO;
      ne_holds_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      x_q         <= x_d;
      s_q         <= s_d;
      t_q         <= t_d;
      quot_q      <= quot_d;
      rem_q       <= rem_d;
      ne_holds_q  <= ne_holds_d;
      div_zero_q  <= div_zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef IC_CHECK_EN
  logic done_s;

  // Invertibility-condition register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ic_q <= 1'b0;
    end else begin
      ic_q <= ic_d;
    end
  end

  assign ic     = ic_q;
  assign done_s = (state_q == ST_DONE);

  ic_ne_bvudiv_checker_sva u_sva (
    .clk      (clk),
    .rst      (rst),
    .done_i   (done_s),
    .ne_holds (ne_holds_q),
    .ic       (ic_q)
  );
`else
  assign ic = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign ne_holds  = ne_holds_q;
  assign div_zero  = div_zero_q;

endmodule

`ifdef IC_CHECK_EN
// ---------------------------------------------------------------------------
// ic_ne_bvudiv_checker_sva
//   Simulation-only property: a holding disequality implies the invertibility
//   condition, so ne_holds & ~ic in DONE indicates a datapath fault.
// Ports
//   clk, rst   clock and synchronous active-high reset
//   done_i     checker is in DONE
//   ne_holds   registered disequality result
//   ic         registered invertibility condition
// ---------------------------------------------------------------------------
module ic_ne_bvudiv_checker_sva (
  input logic clk,
  input logic rst,
  input logic done_i,
  input logic ne_holds,
  input logic ic
);

  a_ne_implies_ic: assert property (@(posedge clk) disable iff (rst)
    (done_i && ne_holds) |-> ic);

endmodule
`endif

// File: tb/tb_ic_ne_bvudiv_checker.sv
// Scoreboard bench for ic_ne_bvudiv_checker (W=4): directed cases followed by
// randomized requests with random back-pressure.
module tb_ic_ne_bvudiv_checker;

  localparam int W    = 4;
  localparam int ONES = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x, s, t;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quot, rem;
  logic         ne_holds, div_zero, ic;

  ic_ne_bvudiv_checker #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .s         (s),
    .t         (t),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .ne_holds  (ne_holds),
    .div_zero  (div_zero),
    .ic        (ic)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q; int r; int ne; int dz; int ic; int acc; int lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: bound expired (t=%0t)", nm, $time);
  endtask

  // Reference model from the arithmetic definition of SMT-LIB bvudiv/bvurem.
  function automatic exp_t model(input int xv, input int sv, input int tv);
    exp_t e;
    e.q  = (sv == 0) ? ONES : xv / sv;
    e.r  = (sv == 0) ? xv   : xv % sv;
    e.ne = (e.q != tv) ? 1 : 0;
    e.dz = (sv == 0) ? 1 : 0;
`ifdef IC_CHECK_EN
    e.ic = ((sv != 0) || (tv != ONES)) ? 1 : 0;
`else
    e.ic = 0;
`endif
    e.lat = (sv == 0) ? 1 : W + 1;
    e.acc = 0;
    return e;
  endfunction

  // Drive one request; waits (bounded) for in_ready, then records the accept.
  task automatic send(input int xv, input int sv, input int tv, input bit keep);
    exp_t e;
    int   k = 0;
    x = xv[W-1:0]; s = sv[W-1:0]; t = tv[W-1:0];
    in_valid = 1'b1;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      fail_now("accept_timeout");
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      e = model(xv, sv, tv);
      e.acc = cyc;
      sb.push_back(e);
      if (!keep) in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || out_valid) && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (k >= 300) fail_now("drain_timeout");
  endtask

  // Back-pressure generator.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = 1'b0;
  end

  // Monitor: pops the expected result when out_valid first appears, then
  // checks the outputs stay frozen until the handshake.
  exp_t cur;
  bit   active = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
    end else if (out_valid) begin
      if (!active) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          cur = sb.pop_front();
          chk("latency",  cyc - cur.acc, cur.lat);
          chk("quot",     int'(quot), cur.q);
          chk("rem",      int'(rem), cur.r);
          chk("ne_holds", int'(ne_holds), cur.ne);
          chk("div_zero", int'(div_zero), cur.dz);
          chk("ic",       int'(ic), cur.ic);
          chk("in_ready_busy", int'(in_ready), 0);
          active = 1'b1;
        end
      end else begin
        chk("hold_quot",     int'(quot), cur.q);
        chk("hold_rem",      int'(rem), cur.r);
        chk("hold_ne",       int'(ne_holds), cur.ne);
        chk("stall_in_ready", int'(in_ready), 0);
      end
      if (out_ready) active = 1'b0;
    end
  end

  initial begin
    int xr, sr, tr, k;
    exp_t m;
    rst = 1'b1; in_valid = 1'b0; x = '0; s = '0; t = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_quot",      int'(quot), 0);
    chk("rst_rem",       int'(rem), 0);
    chk("rst_ic",        int'(ic), 0);
    chk("rst_div_zero",  int'(div_zero), 0);

    // Directed cases.
    send(7, 2, 3, 1'b0);
    send(9, 0, 15, 1'b0);
    send(9, 0, 4, 1'b0);
    wait_drain();

    // Stall with max operands.
    rdy_mode = 2;
    send(15, 15, 0, 1'b0);
    k = 0;
    while (!out_valid && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) fail_now("stall_valid_timeout");
    repeat (6) @(posedge clk);
    rdy_mode = 0;
    wait_drain();

    // Reset in the middle of a division drops it.
    send(13, 3, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_in_ready",  int'(in_ready), 1);
    repeat (8) @(negedge clk);
    chk("midrst_no_output", int'(out_valid), 0);
    send(13, 3, 4, 1'b0);
    wait_drain();

    // Back-to-back with in_valid held high, plus boundary x<s and x=0.
    send(0, 5, 7, 1'b1);
    send(14, 1, 14, 1'b1);
    send(3, 9, 0, 1'b0);
    wait_drain();

    // Randomized requests with random back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      xr = $urandom_range(0, ONES);
      sr = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : $urandom_range(0, ONES);
      m  = model(xr, sr, 0);
      tr = ($urandom_range(0, 1) == 1) ? m.q : $urandom_range(0, ONES);
      send(xr, sr, tr, 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
